// File: rtl/bp_pkg.sv
// Shared types and helpers for the BTB-based dynamic branch predictor.
// Counter encoding, PC slicing constants and the 2-bit saturating update.
package bp_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   localparam int BP_INDEX_BITS = 6;
   localparam int BP_IDX_LSB    = 2;
   localparam int BP_TAG_BITS   = 32 - BP_INDEX_BITS - BP_IDX_LSB;

   function automatic ctr_t sat_update(ctr_t ctr, logic taken);
      ctr_t res;
      res = ctr;
      unique case (ctr)
         SNT: res = taken ? WNT : SNT;
         WNT: res = taken ? WT  : SNT;
         WT:  res = taken ? ST  : WNT;
         ST:  res = taken ? ST  : WT;
         default: res = WNT;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: one async read port for IF, one sync update port for EX.
// The update port does its own hit check so training is a single read-modify-write.
module btb_array
   import bp_pkg::*;
#(
   parameter int INDEX_BITS = BP_INDEX_BITS,
   parameter int TAG_BITS   = BP_TAG_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] rd_idx,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [31:0]           rd_target,
   output ctr_t                  rd_ctr,
   input  logic                  upd_en,
   input  logic                  upd_jump,
   input  logic                  upd_taken,
   input  logic [INDEX_BITS-1:0] upd_idx,
   input  logic [TAG_BITS-1:0]   upd_tag,
   input  logic [31:0]           upd_target
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_BITS-1:0] tag_q [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   ctr_t                ctr_q [ENTRIES];

   logic upd_hit;
   logic alloc;
   logic train;
   logic wr_target;

   assign rd_valid  = valid_q[rd_idx];
   assign rd_tag    = tag_q[rd_idx];
   assign rd_target = target_q[rd_idx];
   assign rd_ctr    = ctr_q[rd_idx];

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      upd_hit   = 1'b0;
      alloc     = 1'b0;
      train     = 1'b0;
      wr_target = 1'b0;
      if (upd_en && !rst) begin
         upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
         alloc     = upd_jump || (!upd_hit && upd_taken);
         train     = !upd_jump && upd_hit;
         wr_target = alloc || (train && upd_taken);
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= WNT;
         end
      end else if (alloc) begin
         valid_q[upd_idx] <= 1'b1;
         ctr_q[upd_idx]   <= upd_jump ? ST : WT;
      end else if (train) begin
         ctr_q[upd_idx] <= sat_update(ctr_q[upd_idx], upd_taken);
      end
   end

   // NOTE: tag/target storage is not reset; a cleared valid bit already makes it unobservable.
   always_ff @(posedge clk) begin
      if (wr_target) begin
         target_q[upd_idx] <= upd_target;
      end
      if (alloc) begin
         tag_q[upd_idx] <= upd_tag;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: IF-side BTB lookup, EX-side resolution/redirect,
// table training on retirement from EX, and retired lookup/mispredict counters.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int INDEX_BITS = BP_INDEX_BITS,
   parameter int TAG_BITS   = 32 - INDEX_BITS - BP_IDX_LSB
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pcF,
   output logic        pred_takenF,
   output logic [31:0] pred_targetF,
   input  logic [31:0] pcE,
   input  logic        pred_takenE,
   input  logic [31:0] pred_targetE,
   input  logic        BranchE,
   input  logic        JumpE,
   input  logic        JalrE,
   input  logic        cond_trueE,
   input  logic [31:0] target_addrE,
   input  logic        advanceE,
   output logic        branch_mispredictE,
   output logic [31:0] redirect_pcE,
   output logic [31:0] lookup_cnt,
   output logic [31:0] mispredict_cnt
);

   logic [INDEX_BITS-1:0] f_idx;
   logic [TAG_BITS-1:0]   f_tag;
   logic                  rd_valid;
   logic [TAG_BITS-1:0]   rd_tag;
   logic [31:0]           rd_target;
   ctr_t                  rd_ctr;
   logic                  f_hit;

   logic        actual_taken;
   logic        is_ctrl;
   logic        upd_en;
   logic [31:0] pcE_plus4;

   assign f_idx     = pcF[BP_IDX_LSB +: INDEX_BITS];
   assign f_tag     = pcF[31 -: TAG_BITS];
   assign f_hit     = rd_valid && (rd_tag == f_tag);
   assign pcE_plus4 = pcE + 32'd4;

   btb_array #(
      .INDEX_BITS(INDEX_BITS),
      .TAG_BITS  (TAG_BITS)
   ) u_btb (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (f_idx),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_target (rd_target),
      .rd_ctr    (rd_ctr),
      .upd_en    (upd_en),
      .upd_jump  (JumpE),
      .upd_taken (JumpE | cond_trueE),
      .upd_idx   (pcE[BP_IDX_LSB +: INDEX_BITS]),
      .upd_tag   (pcE[31 -: TAG_BITS]),
      .upd_target(target_addrE)
   );

   always_comb begin
      pred_takenF  = 1'b0;
      pred_targetF = pcF + 32'd4;
      if (!rst && f_hit && (rd_ctr inside {WT, ST})) begin
         pred_takenF  = 1'b1;
         pred_targetF = rd_target;
      end
   end

   assign actual_taken = JumpE | JalrE | (BranchE & cond_trueE);
   assign is_ctrl      = BranchE | JumpE | JalrE;

   always_comb begin
      branch_mispredictE = 1'b0;
      redirect_pcE       = pcE_plus4;
      if (!rst) begin
         redirect_pcE       = actual_taken ? target_addrE : pcE_plus4;
         branch_mispredictE = (pred_takenE != actual_taken) ||
                              (pred_takenE && actual_taken && (pred_targetE != target_addrE));
      end
   end

   // jalr targets are register-dependent, so they are never cached.
   assign upd_en = advanceE && !JalrE && (BranchE || JumpE);

   always_ff @(posedge clk) begin
      if (rst) begin
         lookup_cnt     <= '0;
         mispredict_cnt <= '0;
      end else if (advanceE) begin
         if (is_ctrl) begin
            lookup_cnt <= lookup_cnt + 32'd1;
         end
         if (branch_mispredictE) begin
            mispredict_cnt <= mispredict_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pcF;
   logic        pred_takenF;
   logic [31:0] pred_targetF;
   logic [31:0] pcE;
   logic        pred_takenE;
   logic [31:0] pred_targetE;
   logic        BranchE;
   logic        JumpE;
   logic        JalrE;
   logic        cond_trueE;
   logic [31:0] target_addrE;
   logic        advanceE;
   logic        branch_mispredictE;
   logic [31:0] redirect_pcE;
   logic [31:0] lookup_cnt;
   logic [31:0] mispredict_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk               (clk),
      .rst               (rst),
      .pcF               (pcF),
      .pred_takenF       (pred_takenF),
      .pred_targetF      (pred_targetF),
      .pcE               (pcE),
      .pred_takenE       (pred_takenE),
      .pred_targetE      (pred_targetE),
      .BranchE           (BranchE),
      .JumpE             (JumpE),
      .JalrE             (JalrE),
      .cond_trueE        (cond_trueE),
      .target_addrE      (target_addrE),
      .advanceE          (advanceE),
      .branch_mispredictE(branch_mispredictE),
      .redirect_pcE      (redirect_pcE),
      .lookup_cnt        (lookup_cnt),
      .mispredict_cnt    (mispredict_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ex_set(input logic br, input logic jmp, input logic jalr, input logic cond,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt, input logic adv);
      BranchE      = br;
      JumpE        = jmp;
      JalrE        = jalr;
      cond_trueE   = cond;
      pcE          = pc;
      target_addrE = tgt;
      pred_takenE  = pt;
      pred_targetE = ptgt;
      advanceE     = adv;
      #1;
   endtask

   task automatic ex_idle();
      ex_set(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4, 1'b0);
   endtask

   task automatic look(input string tag, input logic [31:0] pc, input logic exp_t,
                       input logic [31:0] exp_tgt);
      pcF = pc;
      #1;
      check({tag, "_taken"}, {31'b0, pred_takenF}, {31'b0, exp_t});
      check({tag, "_target"}, pred_targetF, exp_tgt);
   endtask

   task automatic resolve(input string tag, input logic exp_mp, input logic [31:0] exp_rd);
      check({tag, "_mp"}, {31'b0, branch_mispredictE}, {31'b0, exp_mp});
      if (exp_mp) check({tag, "_redirect"}, redirect_pcE, exp_rd);
   endtask

   task automatic counts(input string tag, input logic [31:0] exp_l, input logic [31:0] exp_m);
      check({tag, "_lookup_cnt"}, lookup_cnt, exp_l);
      check({tag, "_mispredict_cnt"}, mispredict_cnt, exp_m);
   endtask

   initial begin
      rst = 1'b1;
      pcF = 32'h100;
      ex_idle();
      step();
      // Outputs forced quiet while reset is asserted.
      ex_set(1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h80, 1'b1);
      check("rst_mp", {31'b0, branch_mispredictE}, 32'h0);
      check("rst_redirect", redirect_pcE, 32'h44);
      step();
      rst = 1'b0;
      ex_idle();
      look("reset", 32'h100, 1'b0, 32'h104);
      counts("reset", 32'd0, 32'd0);

      // Taken branch 0x100 -> 0x80: first allocates WT, second trains to ST.
      ex_set(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104, 1'b1);
      resolve("br_t1", 1'b1, 32'h80);
      look("br_t1_prewrite", 32'h100, 1'b0, 32'h104);
      step();
      look("br_t1_post", 32'h100, 1'b1, 32'h80);
      ex_set(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h80, 1'b1, 32'h80, 1'b1);
      resolve("br_t2", 1'b0, 32'h80);
      step();
      counts("br_t2", 32'd2, 32'd1);

      // Not taken x4: ST->WT->WNT->SNT->SNT.
      ex_set(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80, 1'b1);
      resolve("br_nt1", 1'b1, 32'h104);
      step();
      look("br_nt1_post", 32'h100, 1'b1, 32'h80);
      resolve("br_nt2", 1'b1, 32'h104);
      step();
      look("br_nt2_post", 32'h100, 1'b0, 32'h104);
      ex_set(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'h104, 1'b1);
      resolve("br_nt3", 1'b0, 32'h104);
      step();
      resolve("br_nt4", 1'b0, 32'h104);
      step();
      // One taken from SNT lands on WNT, still not predicted taken.
      ex_set(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104, 1'b1);
      resolve("br_sat_t", 1'b1, 32'h80);
      step();
      look("br_sat_post", 32'h100, 1'b0, 32'h104);
      counts("br_seq", 32'd7, 32'd4);

      // jal 0x200 -> 0x400 stalled three cycles, then retires once.
      ex_set(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h400, 1'b0, 32'h204, 1'b0);
      resolve("jal_stall", 1'b1, 32'h400);
      repeat (3) step();
      ex_idle();
      look("jal_stall_post", 32'h200, 1'b0, 32'h204);
      counts("jal_stall", 32'd7, 32'd4);
      ex_set(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h400, 1'b0, 32'h204, 1'b1);
      step();
      ex_idle();
      look("jal_post", 32'h200, 1'b1, 32'h400);
      counts("jal", 32'd8, 32'd5);
      // Allocated at ST: one not-taken still leaves it predicted taken.
      ex_set(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h400, 1'b1, 32'h400, 1'b1);
      resolve("jal_ctr", 1'b1, 32'h204);
      step();
      ex_idle();
      look("jal_ctr_post", 32'h200, 1'b1, 32'h400);

      // Aliasing on index 0: 0x100 replaces 0x200, then 0x200 replaces 0x100.
      ex_set(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104, 1'b1);
      step();
      ex_idle();
      look("alias_a", 32'h100, 1'b1, 32'h80);
      look("alias_a_other", 32'h200, 1'b0, 32'h204);
      ex_set(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h600, 1'b0, 32'h204, 1'b1);
      step();
      ex_idle();
      look("alias_b", 32'h100, 1'b0, 32'h104);
      look("alias_b_new", 32'h200, 1'b1, 32'h600);
      counts("alias", 32'd11, 32'd8);

      // jalr mispredicts but never touches the BTB.
      ex_set(1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h500, 1'b0, 32'h304, 1'b1);
      resolve("jalr", 1'b1, 32'h500);
      step();
      ex_idle();
      look("jalr_post", 32'h300, 1'b0, 32'h304);
      look("jalr_btb", 32'h200, 1'b1, 32'h600);
      // Predicted-taken target mismatch on a taken branch.
      ex_set(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h640, 1'b1, 32'h600, 1'b0);
      resolve("tgt_mismatch", 1'b1, 32'h640);
      // Non-control instruction predicted taken.
      ex_set(1'b0, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h600, 1'b1);
      resolve("nonctrl", 1'b1, 32'h1004);
      step();
      counts("nonctrl", 32'd12, 32'd10);

      // Reset with an allocation in flight: the allocation must be discarded.
      ex_set(1'b1, 1'b0, 1'b0, 1'b1, 32'h700, 32'h900, 1'b0, 32'h704, 1'b1);
      rst = 1'b1;
      look("rst_flight_if", 32'h200, 1'b0, 32'h204);
      step();
      rst = 1'b0;
      ex_idle();
      look("rst_clr_old", 32'h200, 1'b0, 32'h204);
      look("rst_clr_new", 32'h700, 1'b0, 32'h704);
      counts("rst_clr", 32'd0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
